// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues word fetches and buffers up to DEPTH {pc, instruction} pairs for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects are ignored and flagged on o_align_error.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_req_address,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_resp_valid,
  input  logic [DATA_W-1:0] i_imem_resp_data,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_target,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst_data,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  output logic              o_align_error
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_alloc, r_fill, r_head;
  logic [CNT_W-1:0]  r_occ, r_pend, r_discard;
  logic [DEPTH-1:0]  r_filled;
  logic [ADDR_W-1:0] r_pc_q [DEPTH];
  logic [DATA_W-1:0] r_data_q [DEPTH];
  logic              w_redir, w_acc, w_keep, w_pop, w_inst_valid;
  logic [ADDR_W-1:0] w_target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic r_align_error;
  assign w_redir = i_redirect_valid & (i_redirect_target[1:0] == 2'b00);
  assign w_target = i_redirect_target;
  assign o_align_error = r_align_error;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_align_error <= 1'b0;
    else r_align_error <= i_redirect_valid & (i_redirect_target[1:0] != 2'b00);
`else
  assign w_redir = i_redirect_valid;
  assign w_target = i_redirect_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign o_align_error = 1'b0;
`endif
  assign o_imem_req_valid = i_rst_n & i_enable & ~w_redir & (r_occ != FULL);
  assign o_imem_req_address = r_pc;
  assign w_acc = o_imem_req_valid & i_imem_req_ready;
  assign w_keep = i_imem_resp_valid & (r_discard == '0);
  assign w_inst_valid = r_filled[r_head] & (r_occ != '0);
  assign w_pop = w_inst_valid & i_inst_ready;
  assign o_inst_valid = w_inst_valid;
  assign o_inst_data = w_inst_valid ? r_data_q[r_head] : '0;
  assign o_inst_pc = w_inst_valid ? r_pc_q[r_head] : '0;
  always_ff @(posedge i_clk) begin
    if (w_acc) r_pc_q[r_alloc] <= r_pc;
    if (w_keep) r_data_q[r_fill] <= i_imem_resp_data;
  end
  // r_pend tracks accepted-but-unanswered requests so a redirect knows how many responses to drop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
      r_alloc <= '0;
      r_fill <= '0;
      r_head <= '0;
      r_occ <= '0;
      r_pend <= '0;
      r_discard <= '0;
      r_filled <= '0;
    end else if (w_redir) begin
      r_pc <= w_target;
      r_alloc <= '0;
      r_fill <= '0;
      r_head <= '0;
      r_occ <= '0;
      r_pend <= '0;
      r_filled <= '0;
      r_discard <= r_discard + r_pend - CNT_W'(i_imem_resp_valid);
    end else begin
      if (w_acc) begin
        r_filled[r_alloc] <= 1'b0;
        r_alloc <= r_alloc + PTR_W'(1);
        r_pc <= r_pc + ADDR_W'(4);
      end
      if (w_keep) begin
        r_filled[r_fill] <= 1'b1;
        r_fill <= r_fill + PTR_W'(1);
      end
      if (i_imem_resp_valid & ~w_keep) r_discard <= r_discard - CNT_W'(1);
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_occ <= r_occ + CNT_W'(w_acc) - CNT_W'(w_pop);
      r_pend <= r_pend + CNT_W'(w_acc) - CNT_W'(w_keep);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h100;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  logic clk = 0, rst_n, enable, req_valid, req_ready, resp_valid, redir_valid;
  logic inst_valid, inst_ready, align_err;
  logic [31:0] req_addr, resp_data, redir_target, inst_data, inst_pc;
  logic [31:0] model_pc, exp_pc, last_data;
  logic redir_eff, after_redir, exp_rv;
  mreq_t memq[$];
  logic [31:0] expq[$], pop_log[$];
  int lat, cyc, n_acc, n_pop, snap;
  int n_checks = 0, n_errors = 0;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .o_imem_req_valid(req_valid), .o_imem_req_address(req_addr), .i_imem_req_ready(req_ready),
    .i_imem_resp_valid(resp_valid), .i_imem_resp_data(resp_data),
    .i_redirect_valid(redir_valid), .i_redirect_target(redir_target),
    .o_inst_valid(inst_valid), .o_inst_data(inst_data), .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready), .o_align_error(align_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // memory driver: responses in order, each no earlier than its due edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n && memq.size() > 0 && memq[0].due <= cyc + 1) begin
      resp_valid = 1;
      resp_data = mem_word(memq[0].addr);
    end else begin
      resp_valid = 0;
      resp_data = 0;
    end
  end

  // monitor: sees the values the DUT will sample on the coming rising edge
  always @(negedge clk) if (rst_n) begin
`ifdef FETCH_ALIGN_CHECK_EN
    redir_eff = redir_valid && redir_target[1:0] == 2'b00;
`else
    redir_eff = redir_valid;
`endif
    if (after_redir) check("inst_valid_after_redirect", {31'b0, inst_valid}, 32'b0);
    after_redir = redir_eff;
    exp_rv = enable && !redir_eff && expq.size() < 4;
    check("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
    if (req_valid && req_ready) begin
      check("req_addr", req_addr, model_pc);
      memq.push_back('{req_addr, cyc + 1 + lat});
      expq.push_back(req_addr);
      model_pc = model_pc + 4;
      n_acc++;
    end
    if (resp_valid && memq.size() > 0) void'(memq.pop_front());
    if (redir_eff) begin
      expq.delete();
      model_pc = redir_target & ~32'h3;
    end else if (inst_valid && inst_ready) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got pc %h expected no instruction", inst_pc);
      end else begin
        exp_pc = expq.pop_front();
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", inst_data, mem_word(exp_pc));
      end
      pop_log.push_back(inst_pc);
      last_data = inst_data;
      n_pop++;
    end
  end

  task automatic wait_pops(input int n);
    int k;
    for (k = 0; k < 60 && pop_log.size() < n; k++) step;
    if (pop_log.size() < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_pops: got %0d pops expected %0d", pop_log.size(), n);
    end
  endtask

  task automatic drain;
    int k;
    enable = 0;
    inst_ready = 1;
    for (k = 0; k < 80 && (memq.size() != 0 || expq.size() != 0 || inst_valid); k++) step;
    if (memq.size() != 0 || expq.size() != 0 || inst_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d outstanding %0d buffered expected 0 0", memq.size(), expq.size());
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid = 1;
    redir_target = t;
    step;
    redir_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; enable = 1; req_ready = 1; inst_ready = 1; redir_valid = 0; redir_target = 0;
    resp_valid = 0; resp_data = 0; lat = 1; cyc = 0; n_acc = 0; n_pop = 0;
    model_pc = RST_PC; after_redir = 0;
    repeat (2) step;
    check("rst_req_valid", {31'b0, req_valid}, 32'b0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'b0);
    check("rst_align_error", {31'b0, align_err}, 32'b0);
    check("rst_inst_data", inst_data, 32'b0);
    check("rst_inst_pc", inst_pc, 32'b0);
    rst_n = 1;
    @(negedge clk);
    check("first_req_valid", {31'b0, req_valid}, 32'b1);
    check("first_req_addr", req_addr, 32'h100);
    repeat (8) step;
    snap = n_pop;
    repeat (10) step;
    check("steady_pops", n_pop - snap, 10);
    check("stream_pc2", pop_log[2], 32'h108);
    // full buffer stalls requests; one pop frees exactly one slot
    drain;
    lat = 1; inst_ready = 0; n_acc = 0; enable = 1;
    repeat (10) step;
    check("full_accepts", n_acc, 4);
    check("full_req_valid", {31'b0, req_valid}, 32'b0);
    inst_ready = 1;
    step;
    inst_ready = 0;
    check("pop_frees_req", {31'b0, req_valid}, 32'b1);
    step;
    check("one_more_accept", n_acc, 5);
    repeat (3) step;
    check("refull_accepts", n_acc, 5);
    check("refull_req_valid", {31'b0, req_valid}, 32'b0);
    // redirect with two responses still in flight
    drain;
    lat = 3; pop_log.delete(); enable = 1;
    repeat (2) step;
    check("outstanding", memq.size(), 2);
    redirect(32'h400);
    check("redir_req_addr", req_addr, 32'h400);
    wait_pops(1);
    check("redir_first_pc", pop_log[0], 32'h400);
    check("redir_first_data", last_data, 32'h5A5A_0400);
    // PC wraps modulo 2^ADDR_W
    lat = 1; pop_log.delete();
    redirect(32'hFFFF_FFF8);
    wait_pops(3);
    check("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
    check("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
    check("wrap_pc2", pop_log[2], 32'h0);
    // misaligned redirect
    pop_log.delete();
    redirect(32'h202);
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_pulse", {31'b0, align_err}, 32'b1);
    step;
    check("align_pulse_end", {31'b0, align_err}, 32'b0);
    wait_pops(1);
    check("align_ignored", {31'b0, pop_log[0] == 32'h200}, 32'b0);
`else
    check("align_tied_low", {31'b0, align_err}, 32'b0);
    wait_pops(1);
    check("align_forced_pc", pop_log[0], 32'h200);
`endif
    // asynchronous reset mid-stream
    drain;
    lat = 1; inst_ready = 0; enable = 1;
    repeat (4) step;
    check("prefill_valid", {31'b0, inst_valid}, 32'b1);
    @(posedge clk);
    #2;
    rst_n = 0;
    memq.delete(); expq.delete(); resp_valid = 0; model_pc = RST_PC; after_redir = 0;
    #1;
    check("async_inst_valid", {31'b0, inst_valid}, 32'b0);
    check("async_req_valid", {31'b0, req_valid}, 32'b0);
    step;
    rst_n = 1; inst_ready = 1; pop_log.delete();
    @(negedge clk);
    check("restart_req_addr", req_addr, 32'h100);
    wait_pops(1);
    check("restart_pc", pop_log[0], 32'h100);
    drain;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
